// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared comma constants, aligner state type and counter helper
package serdes_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;
    localparam logic [6:0] COMMA_P   = 7'h7C;
    localparam logic [6:0] COMMA_N   = 7'h03;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/comma_detect.sv
// rtl/comma_detect.sv - flags a K28.5 abcdeif comma at the bottom of a 10-bit window
module comma_detect
    import serdes_pkg::*;
(
    input  logic [9:0] window,
    output logic       hit
);

    // Only the oldest seven bits identify the comma; fghj are don't-care.
    logic unusedBits;
    assign unusedBits = ^window[9:7];

    assign hit = (window[6:0] == COMMA_P) || (window[6:0] == COMMA_N);

endmodule

// File: rtl/comma_aligner.sv
// rtl/comma_aligner.sv - serial K28.5 word aligner with lock/unlock hysteresis
module comma_aligner
    import serdes_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3
) (
    input  logic       BitCLK,
    input  logic       Reset,
    input  logic       Serial_in,
    input  logic       Align_En,
    output logic [9:0] RxParallel_10,
    output logic       Word_Valid,
    output logic       Comma_Det,
    output logic       Locked,
    output logic       Realign
);

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    logic [9:0]   sr;
    logic [3:0]   ph;
    logic [3:0]   alignPh;
    align_state_t state;
    logic [3:0]   lockCnt;
    logic [3:0]   missCnt;

    align_state_t stateNext;
    logic [3:0]   alignPhNext;
    logic [3:0]   lockCntNext;
    logic [3:0]   missCntNext;
    logic         realignNext;
    logic         emit;
    logic         hit;
    logic         aligned;
    logic [3:0]   lockInc;
    logic [3:0]   missInc;

    comma_detect uDetect (
        .window (sr),
        .hit    (hit)
    );

    assign aligned = (ph == alignPh);
    assign lockInc = satInc(lockCnt);
    assign missInc = satInc(missCnt);

    always_comb begin
        stateNext   = state;
        alignPhNext = alignPh;
        lockCntNext = lockCnt;
        missCntNext = missCnt;
        realignNext = 1'b0;
        emit        = 1'b0;
        case (state)
            HUNT: begin
                if (hit && Align_En) begin
                    emit        = 1'b1;
                    alignPhNext = ph;
                    lockCntNext = 4'd1;
                    missCntNext = 4'd0;
                    realignNext = 1'b1;
                    stateNext   = (LOCK_TGT == 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                emit = aligned;
                if (hit && aligned) begin
                    lockCntNext = lockInc;
                    if (lockInc == LOCK_TGT) begin
                        stateNext   = LOCKED;
                        missCntNext = 4'd0;
                    end
                end else if (hit && Align_En) begin
                    alignPhNext = ph;
                    lockCntNext = 4'd1;
                    realignNext = 1'b1;
                end
            end
            LOCKED: begin
                emit = aligned;
                if (hit && aligned) begin
                    missCntNext = 4'd0;
                end else if (hit && Align_En) begin
                    // Only a run of misaligned commas moves a locked boundary.
                    if (missInc == UNLOCK_TGT) begin
                        alignPhNext = ph;
                        lockCntNext = 4'd1;
                        missCntNext = 4'd0;
                        realignNext = 1'b1;
                        stateNext   = (LOCK_TGT == 4'd1) ? LOCKED : VERIFY;
                    end else begin
                        missCntNext = missInc;
                    end
                end
            end
            default: stateNext = HUNT;
        endcase
    end

    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            sr            <= '0;
            ph            <= '0;
            alignPh       <= '0;
            state         <= HUNT;
            lockCnt       <= '0;
            missCnt       <= '0;
            RxParallel_10 <= '0;
            Word_Valid    <= 1'b0;
            Comma_Det     <= 1'b0;
            Locked        <= 1'b0;
            Realign       <= 1'b0;
        end else begin
            sr      <= {Serial_in, sr[9:1]};
            ph      <= (ph == 4'd9) ? 4'd0 : ph + 4'd1;
            alignPh <= alignPhNext;
            state   <= stateNext;
            lockCnt <= lockCntNext;
            missCnt <= missCntNext;
            if (emit) begin
                RxParallel_10 <= sr;
            end
            Word_Valid <= emit;
            Comma_Det  <= emit && hit;
            Locked     <= (stateNext == LOCKED);
            Realign    <= realignNext;
        end
    end

endmodule

// File: tb/tb_comma_aligner.sv
// tb/tb_comma_aligner.sv - directed scoreboard bench for comma_aligner
module tb_comma_aligner;
    import serdes_pkg::*;

    logic       BitCLK = 1'b0;
    logic       Reset;
    logic       Serial_in;
    logic       Align_En;
    logic [9:0] RxParallel_10;
    logic       Word_Valid;
    logic       Comma_Det;
    logic       Locked;
    logic       Realign;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int realignCount = 0;
    int wvCount = 0;
    int lastWv = 0;
    bit haveLast = 0;
    bit gapEn = 0;
    logic [10:0] expQ[$];

    comma_aligner #(.LOCK_CNT(3), .UNLOCK_CNT(3)) dut (
        .BitCLK        (BitCLK),
        .Reset         (Reset),
        .Serial_in     (Serial_in),
        .Align_En      (Align_En),
        .RxParallel_10 (RxParallel_10),
        .Word_Valid    (Word_Valid),
        .Comma_Det     (Comma_Det),
        .Locked        (Locked),
        .Realign       (Realign)
    );

    always #5 BitCLK = ~BitCLK;

    always @(posedge BitCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop one expected word per Word_Valid pulse.
    always @(negedge BitCLK) begin
        logic [10:0] e;
        if (!Reset) begin
            if (Realign) realignCount++;
            check("cdet_qual", 32'(Comma_Det & ~Word_Valid), 32'd0);
            if (!gapEn) haveLast = 0;
            if (Word_Valid) begin
                wvCount++;
                if (gapEn && haveLast) check("wv_gap", 32'(cyc - lastWv), 32'd10);
                lastWv = cyc;
                haveLast = gapEn;
                check("sb_avail", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    check("word", 32'(RxParallel_10), 32'(e[9:0]));
                    check("comma", 32'(Comma_Det), 32'(e[10]));
                end
            end
        end
    end

    task automatic sendBit(input logic b);
        Serial_in = b;
        @(posedge BitCLK);
        #1;
    endtask

    task automatic sendBits(input logic [9:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) sendBit(w[i]);
    endtask

    task automatic sendWord(input logic [9:0] w);
        sendBits(w, 0, 9);
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
    endtask

    task automatic pushExp(input logic [9:0] w, input logic c);
        expQ.push_back({c, w});
    endtask

    task automatic checkResetOutputs();
        check("rst_data", 32'(RxParallel_10), 32'd0);
        check("rst_wv", 32'(Word_Valid), 32'd0);
        check("rst_cdet", 32'(Comma_Det), 32'd0);
        check("rst_locked", 32'(Locked), 32'd0);
        check("rst_realign", 32'(Realign), 32'd0);
    endtask

    initial begin
        logic [9:0] k;
        logic [9:0] wFirst;
        logic [9:0] wMid;
        logic [9:0] s2[9];
        int rBase;
        int wvBase;

        k = K28_5_RDN;
        // 4-bit slip of zeros seen through the old boundary
        wFirst = {k[5:0], 4'b0000};
        wMid   = {k[5:0], k[9:6]};
        s2 = '{K28_5_RDN, K28_5_RDP, K28_5_RDN, K28_5_RDP,
               10'h155, 10'h155, 10'h155, 10'h155, 10'h155};

        Reset = 1'b1;
        Serial_in = 1'b0;
        Align_En = 1'b1;

        // 1: reset, filler, acquire lock
        sendZeros(2);
        checkResetOutputs();
        Reset = 1'b0;
        gapEn = 1;
        rBase = realignCount;
        sendZeros(3);
        for (int i = 1; i <= 5; i++) begin
            pushExp(k, 1'b1);
            sendWord(k);
            if (i == 3) check("s1_locked_lo", 32'(Locked), 32'd0);
            if (i == 4) check("s1_locked_hi", 32'(Locked), 32'd1);
        end
        check("s1_realign", 32'(realignCount - rBase), 32'd1);

        // 2: mixed disparity commas and data while locked
        rBase = realignCount;
        for (int i = 0; i < 9; i++) begin
            pushExp(s2[i], (s2[i] != 10'h155));
            sendWord(s2[i]);
        end
        check("s2_locked", 32'(Locked), 32'd1);
        check("s2_realign", 32'(realignCount - rBase), 32'd0);
        gapEn = 0;

        // 3: 4-bit slip with realignment enabled
        rBase = realignCount;
        pushExp(wFirst, 1'b0);
        pushExp(wMid, 1'b0);
        pushExp(wMid, 1'b0);
        for (int i = 0; i < 3; i++) pushExp(k, 1'b1);
        sendZeros(4);
        for (int i = 1; i <= 6; i++) begin
            sendWord(k);
            if (i == 3) begin
                check("s3_realign_pre", 32'(realignCount - rBase), 32'd0);
                check("s3_locked_pre", 32'(Locked), 32'd1);
            end
            if (i == 4) begin
                check("s3_realign", 32'(realignCount - rBase), 32'd1);
                check("s3_unlocked", 32'(Locked), 32'd0);
            end
            if (i == 5) check("s3_verify", 32'(Locked), 32'd0);
            if (i == 6) check("s3_relocked", 32'(Locked), 32'd1);
        end

        // 4: same slip with the boundary frozen
        rBase = realignCount;
        Align_En = 1'b0;
        pushExp(wFirst, 1'b0);
        for (int i = 0; i < 5; i++) pushExp(wMid, 1'b0);
        sendZeros(4);
        for (int i = 0; i < 6; i++) sendWord(k);
        sendZeros(3);
        check("s4_locked", 32'(Locked), 32'd1);
        check("s4_realign", 32'(realignCount - rBase), 32'd0);

        // 5: one-cycle reset mid-word while locked
        Reset = 1'b1;
        sendBit(1'b0);
        Reset = 1'b0;
        Align_En = 1'b1;
        checkResetOutputs();
        check("s5_sb_drained", 32'(expQ.size()), 32'd0);
        rBase = realignCount;
        for (int i = 1; i <= 4; i++) begin
            pushExp(k, 1'b1);
            sendWord(k);
            if (i == 3) check("s5_locked_lo", 32'(Locked), 32'd0);
            if (i == 4) check("s5_locked_hi", 32'(Locked), 32'd1);
        end
        sendZeros(5);
        check("s5_realign", 32'(realignCount - rBase), 32'd1);

        // 6: alignment disabled from reset, then enabled
        Reset = 1'b1;
        Align_En = 1'b0;
        sendBit(1'b0);
        Reset = 1'b0;
        check("s6_sb_drained", 32'(expQ.size()), 32'd0);
        rBase = realignCount;
        wvBase = wvCount;
        sendZeros(3);
        for (int i = 0; i < 5; i++) sendWord(k);
        check("s6_no_wv", 32'(wvCount - wvBase), 32'd0);
        check("s6_no_lock", 32'(Locked), 32'd0);
        check("s6_no_realign", 32'(realignCount - rBase), 32'd0);
        for (int i = 0; i < 4; i++) pushExp(k, 1'b1);
        sendBits(k, 0, 0);
        Align_En = 1'b1;
        sendBits(k, 1, 9);
        sendWord(k);
        sendWord(k);
        check("s6_locked_lo", 32'(Locked), 32'd0);
        sendWord(k);
        check("s6_locked_hi", 32'(Locked), 32'd1);
        sendZeros(5);
        check("s6_sb_done", 32'(expQ.size()), 32'd0);
        check("s6_realign", 32'(realignCount - rBase), 32'd1);
        check("s6_wv_count", 32'(wvCount - wvBase), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Receive-side word aligner between the serial input pin and the 10b/8b decoder.
- Shifts in Serial_in on BitCLK and hunts for the K28.5 comma.
- Locks the 10-bit symbol boundary after repeated aligned commas and emits aligned 10-bit code groups with a one-cycle valid strobe.
- Handoff of the aligned words to the BitCLK_10 decoder domain is outside this block.

Parameters:
- LOCK_CNT, 3: consecutive aligned commas required to declare lock (range 1..15).
- UNLOCK_CNT, 3: consecutive misaligned commas in LOCKED that force a realign (range 1..15).

Ports:
- BitCLK  input  1  bit clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- Serial_in  input  1  received serial bit. Transmit order is a first, j last.
- Align_En  input  1  when high, commas may set or move the boundary; when low, the boundary is frozen.
- RxParallel_10  output  10  aligned code group. Bit 0 = a (first received bit), bit 9 = j.
- Word_Valid  output  1  one-cycle pulse when RxParallel_10 is updated.
- Comma_Det  output  1  qualifies Word_Valid; high when the emitted word contains a comma.
- Locked  output  1  high in LOCKED state.
- Realign  output  1  one-cycle pulse whenever the boundary phase changes.

Behaviour:
- All registers update on the BitCLK rising edge. Reset is synchronous and active-high.
- Reset values: sr=0, ph=0, align_ph=0, state=HUNT, all counters 0, and every output 0. A reset mid-operation discards the partial word and the lock.
- Shift register: each cycle sr <= {Serial_in, sr[9:1]}. The newest bit lands at sr[9]; the oldest is at sr[0].
- Phase counter: ph counts 0..9 every cycle and wraps from 9 to 0. It is free-running and independent of state.
- Comma detection: hit = (sr[6:0]==7'h7C) or (sr[6:0]==7'h03). This is the abcdeif comma, either running disparity.
  - When hit is true, sr holds a complete symbol, for example 0x17C (K28.5 RD-) or 0x283 (K28.5 RD+).
  - aligned = (ph==align_ph).
- Word output (registered; outputs appear one edge after sr holds the symbol):
  - In VERIFY or LOCKED with aligned: RxParallel_10<=sr, Word_Valid<=1, Comma_Det<=hit.
  - In HUNT with hit and Align_En: same capture; this first comma word is emitted.
  - Otherwise Word_Valid<=0, Comma_Det<=0, and RxParallel_10 holds its value.
- Steady state: Word_Valid fires exactly every 10 cycles.
- State machine:
  - HUNT: if hit and Align_En, then align_ph<=ph, lock_cnt<=1, Realign pulse. Go to LOCKED if LOCK_CNT==1, else VERIFY. Otherwise stay in HUNT.
  - VERIFY, hit and aligned: lock_cnt++. When the incremented value equals LOCK_CNT, go to LOCKED, miss_cnt<=0.
  - VERIFY, hit and not aligned and Align_En: align_ph<=ph, lock_cnt<=1, Realign pulse, stay in VERIFY.
  - VERIFY, non-comma words: no effect.
  - LOCKED, hit and aligned: miss_cnt<=0.
  - LOCKED, hit and not aligned and Align_En: miss_cnt++. When it reaches UNLOCK_CNT: align_ph<=ph, lock_cnt<=1, miss_cnt<=0, Realign pulse, go to VERIFY (Locked drops on the same edge). If LOCK_CNT==1, go directly back to LOCKED with the new phase.
  - LOCKED, non-comma aligned words: leave miss_cnt unchanged.
- Align_En low: misaligned commas are ignored in every state, and HUNT is never exited. Aligned commas still count in VERIFY.
- Locked is registered from the state and changes on the same edge as the state.
- Counters saturate; they cannot wrap.

Decomposition:
- Shared package serdes_pkg holds:
  - K28_5_RDN=10'h17C and K28_5_RDP=10'h283.
  - COMMA_P=7'h7C and COMMA_N=7'h03.
  - The align_state_t enum {HUNT, VERIFY, LOCKED}.
- One natural combinational sub-module, comma_detect: 10-bit window in, hit out. It is reusable by a later word-lock monitor.

Test Plan:
1. Reset, 3 filler zero bits, then repeated 0x17C LSB-first.
   - Realign on the first comma; Locked=1 on the edge after the 3rd comma.
   - Word_Valid every 10 cycles with RxParallel_10=0x17C and Comma_Det=1.
2. After lock, alternate 0x17C/0x283 then send D21.5 (0x155) ×5.
   - Words 0x283 (Comma_Det=1) and 0x155 (Comma_Det=0) follow; Locked stays 1 and there is no Realign.
3. In LOCKED, insert a 4-bit slip, then 0x17C ×6.
   - 1st and 2nd misaligned commas: no change.
   - 3rd: Realign pulse and Locked=0.
   - Two further aligned commas: Locked=1, with Word_Valid at the new phase.
4. As scenario 3 but with Align_En=0 throughout the slip.
   - No Realign, Locked held at 1, words emitted at the old phase (misaligned data).
5. Reset asserted for 1 cycle mid-word while LOCKED.
   - Next edge: all outputs 0 and state HUNT.
   - Relock requires 3 fresh commas.
6. Align_En=0 from reset with continuous commas.
   - Word_Valid never asserts and Locked stays 0.
   - Raising Align_En produces a lock after LOCK_CNT commas.
